// File: rtl/soda_pkg.sv
// Shared constants and types for the soda dispenser change-return path.
package soda_pkg;

  localparam int unsigned SODA_AMT_W = 9;
  localparam int unsigned SODA_CNT_W = 8;
  localparam int unsigned SODA_S_W   = 8;

  localparam int unsigned COIN_N = 5;
  localparam int unsigned COIN_D = 10;
  localparam int unsigned COIN_Q = 25;

  localparam logic [1:0] COIN_T_NONE    = 2'b00;
  localparam logic [1:0] COIN_T_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_T_DIME    = 2'b10;
  localparam logic [1:0] COIN_T_QUARTER = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EJECT  = 2'd2,
    ST_DONE   = 2'd3
  } chg_state_e;

endpackage

// File: rtl/soda_coin_select.sv
// Greedy coin picker: largest coin not exceeding the remaining change.
module soda_coin_select
  import soda_pkg::*;
#(
  parameter int unsigned AMT_W = SODA_AMT_W
) (
  input  logic [AMT_W-1:0] rem,
  output logic [1:0]       coin_type_c,
  output logic [AMT_W-1:0] coin_value_c
);

  always_comb begin
    coin_type_c  = COIN_T_NONE;
    coin_value_c = '0;
    if (rem >= AMT_W'(COIN_Q)) begin
      coin_type_c  = COIN_T_QUARTER;
      coin_value_c = AMT_W'(COIN_Q);
    end else if (rem >= AMT_W'(COIN_D)) begin
      coin_type_c  = COIN_T_DIME;
      coin_value_c = AMT_W'(COIN_D);
    end else if (rem >= AMT_W'(COIN_N)) begin
      coin_type_c  = COIN_T_NICKEL;
      coin_value_c = AMT_W'(COIN_N);
    end
  end

endmodule

// File: rtl/soda_change_dispenser.sv
// Change return controller: pays (tot - s) back one coin at a time through a
// request/acknowledge coin ejector, quarters first.
module soda_change_dispenser
  import soda_pkg::*;
#(
  parameter int unsigned AMT_W = SODA_AMT_W,
  parameter int unsigned CNT_W = SODA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] tot,
  input  logic [7:0]       s,
  input  logic             coin_ack,
  output logic             coin_eject,
  output logic [1:0]       coin_type,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] coins_out
);

  chg_state_e       state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [1:0]       coin_type_q, coin_type_d;
  logic             coin_eject_q, coin_eject_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] coins_out_q, coins_out_d;

  logic [1:0]       sel_type;
  logic [AMT_W-1:0] sel_value;
  logic [AMT_W-1:0] price;

  assign price = AMT_W'(s);

  // rem is stable throughout EJECT, so the same pick drives the subtraction.
  soda_coin_select #(.AMT_W(AMT_W)) u_coin_select (
    .rem          (rem_q),
    .coin_type_c  (sel_type),
    .coin_value_c (sel_value)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    coin_type_d = coin_type_q;
    err_d       = err_q;
    coins_out_d = coins_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (tot >= price) begin
            rem_d = tot - price;
            err_d = 1'b0;
          end else begin
            rem_d = '0;
            err_d = 1'b1;
          end
          coins_out_d = '0;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        coin_type_d = sel_type;
        if (sel_type != COIN_T_NONE) begin
          state_d = ST_EJECT;
        end else begin
          // Leftover below a nickel cannot be paid out.
          if (rem_q != '0) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_EJECT: begin
        if (coin_ack) begin
          rem_d = rem_q - sel_value;
          if (coins_out_q != {CNT_W{1'b1}}) coins_out_d = coins_out_q + CNT_W'(1);
          state_d = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Moore outputs decoded from the next state so they appear with it.
    coin_eject_d = (state_d == ST_EJECT);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      coin_type_q  <= COIN_T_NONE;
      coin_eject_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      coins_out_q  <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      coin_type_q  <= coin_type_d;
      coin_eject_q <= coin_eject_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      coins_out_q  <= coins_out_d;
    end
  end

  assign coin_eject = coin_eject_q;
  assign coin_type  = coin_type_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign coins_out  = coins_out_q;

endmodule
